// File: rtl/alarma_temp_fsm.sv
// Operator-facing temperature alarm controller.
// Consumes debounced persistence flags and raw threshold flags, raises
// cold/hot alarms, waits for a run of in-range samples before clearing,
// then holds a blinking memory state until the operator acknowledges.
//
// state   | meaning
// --------+--------------------------------------------------------------
// NORMAL  | no alarm, all indicators off
// FRIO    | cold alarm active, LED steady, buzzer unless silenced
// CALOR   | hot alarm active, LED steady, buzzer unless silenced
// MEMORIA | alarm cleared but not acknowledged, LED blinking
module alarma_temp_fsm #(
  parameter int N_REC     = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       per_bajo,
  input  logic       per_alto,
  input  logic       es_bajo,
  input  logic       es_alto,
  input  logic       ack,
  output logic [2:0] estado,
  output logic       alarma_frio,
  output logic       alarma_calor,
  output logic       buzzer,
  output logic       led,
  output logic [7:0] n_eventos
);

  typedef enum logic [2:0] {
    NORMAL  = 3'd0,
    FRIO    = 3'd1,
    CALOR   = 3'd2,
    MEMORIA = 3'd3
  } state_t;

  localparam logic [3:0] REC_LAST   = 4'(N_REC - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

  state_t     st;
  state_t     nxt;
  logic [3:0] rec_cnt;
  logic [3:0] rec_nxt;
  logic [7:0] blink_cnt;
  logic       silencio;
  logic       sil_nxt;
  logic       en_rango;
  logic       entra_alarma;
  logic       nxt_alarma;

  assign estado   = st;
  assign en_rango = !es_bajo && !es_alto;

  // Next-state, recovery counter and silence flag decisions.
  always_comb begin
    nxt     = NORMAL;
    rec_nxt = '0;
    case (st)
      NORMAL: begin
        if (per_alto)      nxt = CALOR;
        else if (per_bajo) nxt = FRIO;
        else               nxt = NORMAL;
      end
      FRIO, CALOR: begin
        nxt = st;
        if (per_alto)      nxt = CALOR;
        else if (per_bajo) nxt = FRIO;
        else if (en_rango) begin
          if (rec_cnt == REC_LAST) nxt = MEMORIA;
          else                     rec_nxt = rec_cnt + 4'd1;
        end
      end
      MEMORIA: begin
        if (per_alto)      nxt = CALOR;
        else if (per_bajo) nxt = FRIO;
        else if (ack)      nxt = NORMAL;
        else               nxt = MEMORIA;
      end
      default: nxt = NORMAL;
    endcase

    nxt_alarma   = (nxt == FRIO) || (nxt == CALOR);
    entra_alarma = nxt_alarma && (nxt != st);

    sil_nxt = silencio;
    if (entra_alarma)
      sil_nxt = 1'b0;
    else if (ack && (nxt == st) && ((st == FRIO) || (st == CALOR)))
      sil_nxt = 1'b1;
  end

  // State register and registered output decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= NORMAL;
      rec_cnt      <= '0;
      blink_cnt    <= '0;
      silencio     <= 1'b0;
      alarma_frio  <= 1'b0;
      alarma_calor <= 1'b0;
      buzzer       <= 1'b0;
      led          <= 1'b0;
      n_eventos    <= '0;
    end else begin
      st           <= nxt;
      rec_cnt      <= rec_nxt;
      silencio     <= sil_nxt;
      alarma_frio  <= (nxt == FRIO);
      alarma_calor <= (nxt == CALOR);
      buzzer       <= nxt_alarma && !sil_nxt;

      if (nxt == MEMORIA) begin
        if (st != MEMORIA) begin
          blink_cnt <= '0;
          led       <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          led       <= ~led;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end else begin
        blink_cnt <= '0;
        led       <= nxt_alarma;
      end

      if (entra_alarma && (n_eventos != 8'hFF))
        n_eventos <= n_eventos + 8'd1;
    end
  end

endmodule
